// File: rtl/fifo_fwft_if.sv
// Handshake and status bundle for fifo_fwft; the producer/consumer side uses
// the master modport and the FIFO itself uses the slave modport.
interface fifo_fwft_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 512
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             push;
  logic [WIDTH-1:0] data_in;
  logic             pop;
  logic             clear_err;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, data_in, pop, clear_err,
    input  data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  push, data_in, pop, clear_err,
    output data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );
endinterface

// File: rtl/fifo_fwft.sv
// First-word-fall-through FIFO: every entry lives in a synchronous-read RAM and
// data_out is a prefetch register holding a copy of the front entry.
module fifo_fwft #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 512,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input logic         clk,
  input logic         rst,
  fifo_fwft_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C     = CW'(AE_LEVEL);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      rd_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] data_q;
  logic             overflow_q;
  logic             underflow_q;
  logic             empty_c;
  logic             full_c;
  logic             push_ok;
  logic             pop_ok;

  // Pointers carry one extra MSB, so their difference spans 0..DEPTH exactly.
  assign count   = wr_ptr - rd_ptr;
  assign rd_next = rd_ptr + PTR_ONE;
  assign empty_c = (count == '0);
  assign full_c  = (count == DEPTH_C);
  assign pop_ok  = bus.pop & ~empty_c;
  assign push_ok = bus.push & (~full_c | pop_ok);

  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem[wr_ptr[AW-1:0]] <= bus.data_in;
    end
  end

  // The front entry comes from RAM when one remains behind it; otherwise an
  // incoming word becoming the front is bypassed straight from data_in.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (pop_ok && (count > CNT_ONE)) begin
      data_q <= mem[rd_next[AW-1:0]];
    end else if (push_ok && (empty_c || pop_ok)) begin
      data_q <= bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr <= rd_next;
      end
      if (bus.clear_err) begin
        overflow_q  <= 1'b0;
        underflow_q <= 1'b0;
      end else begin
        overflow_q  <= overflow_q  | (bus.push & ~push_ok);
        underflow_q <= underflow_q | (bus.pop  & ~pop_ok);
      end
    end
  end

  assign bus.data_out     = data_q;
  assign bus.count        = count;
  assign bus.empty        = empty_c;
  assign bus.full         = full_c;
  assign bus.almost_full  = (count >= AF_C);
  assign bus.almost_empty = (count <= AE_C);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: doc/fifo_fwft.md
FIFO_FWFT -- requirements
Module: fifo_fwft

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data bits per entry, legal range 1..32.
REQ-002 SHALL have parameter DEPTH, default 512: number of entries, a power of two, legal range 4..4096.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-4: almost_full threshold, legal range 1..DEPTH-1.
REQ-004 SHALL have parameter AE_LEVEL, default 4: almost_empty threshold, legal range 1..DEPTH-1.
REQ-005 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1  reset: synchronous, active-high.
REQ-007 SHALL have port push  input  1  write request; data_in is sampled in the same cycle.
REQ-008 SHALL have port data_in  input  WIDTH  write data.
REQ-009 SHALL have port pop  input  1  read request; consumes the element on data_out in the same cycle.
REQ-010 SHALL have port data_out  output  WIDTH  front element, valid whenever empty=0.
REQ-011 SHALL have port full  output  1  count==DEPTH.
REQ-012 SHALL have port empty  output  1  no element is visible on data_out.
REQ-013 SHALL have port almost_full  output  1  count>=AF_LEVEL.
REQ-014 SHALL have port almost_empty  output  1  count<=AE_LEVEL.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  number of stored elements.
REQ-016 SHALL have port overflow  output  1  sticky: a push was rejected.
REQ-017 SHALL have port underflow  output  1  sticky: a pop was rejected.
REQ-018 SHALL have port clear_err  input  1  clears overflow and underflow.

Function
REQ-019 SHALL store entries in an inferred block RAM with synchronous read, plus an output register that prefetches the front element (first-word-fall-through).
REQ-020 SHALL accept push only if full=0 or pop is accepted in the same cycle.
- A rejected push leaves contents unchanged and sets overflow on the next edge.
REQ-021 SHALL accept pop only if empty=0.
- A rejected pop leaves state unchanged and sets underflow on the next edge.
REQ-022 SHALL allow push and pop in consecutive and identical cycles, with no idle-cycle restriction.
REQ-023 SHALL update count registered:
- +1 on accepted push only.
- -1 on accepted pop only.
- Unchanged when both are accepted or neither is.
REQ-024 SHALL derive full, almost_full and almost_empty combinationally from the registered count.
REQ-025 SHALL deassert empty exactly 1 cycle after a push into an empty FIFO, with data_out equal to that pushed word.
- First-word latency: push in cycle N -> visible in cycle N+1.
REQ-026 SHALL present the next element on data_out in the cycle after an accepted pop, when count>=2 before that pop.
REQ-027 SHALL present the pushed word in cycle N+1 for a simultaneous push and pop in cycle N with count==1.
- empty stays 0 throughout.
REQ-028 SHALL wrap read and write addresses modulo DEPTH, using an extra MSB to distinguish full from empty.
REQ-029 SHALL hold data_out stable while empty=0 and pop=0.
- data_out content is don't-care while empty=1.
REQ-030 SHALL give clear_err priority over a same-cycle set.
- Flags read 0 on the next cycle.

Reset
REQ-031 SHALL, on rst=1 at a clock edge, set:
- count=0, empty=1, full=0, almost_full=0, almost_empty=1, overflow=0, underflow=0.
- Read and write pointers to 0.
- data_out to 0.
REQ-032 SHALL take effect on reset asserted mid-operation in the next cycle.
- Any same-cycle push or pop is discarded.
- Stored data is lost.
REQ-033 SHALL require no RAM initialisation; RAM contents are not reset.

Verification (WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2)
REQ-034 SHALL verify first-word fall-through: push 0xA5 into an empty FIFO -> next cycle empty=0, data_out=0xA5, count=1.
REQ-035 SHALL verify fill and overflow: push 0x01..0x08 -> full=1, almost_full=1 from count 6, count=8.
- A 9th push -> overflow=1, count stays 8.
- Pop all -> 0x01..0x08 in order.
REQ-036 SHALL verify back-to-back pops: with 3 entries, pop in 3 consecutive cycles -> data_out shows 0x01, 0x02, 0x03 on successive cycles.
- empty=1 after the third pop, underflow=0.
REQ-037 SHALL verify simultaneous push/pop: count=1 (0x10), push 0x20 and pop together -> count=1, data_out=0x20 next cycle, empty never 1.
REQ-038 SHALL verify underflow and clear: pop while empty -> underflow=1, count=0.
- clear_err together with another pop -> underflow=0 on the next cycle.
REQ-039 SHALL verify wrap and reset: 20 random push/pop mixes crossing the address wrap -> order preserved against a reference model.
- rst asserted mid-stream -> next cycle count=0, empty=1, flags=0.
